// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - shared fetch state encodings and PC helpers
package instruction_fetch_unit_pkg;

    typedef enum logic [2:0] {
        FS_IDLE     = 3'd0,
        FS_WAIT_ACK = 3'd1,
        FS_DONE     = 3'd2,
        FS_RELEASE  = 3'd3,
        FS_FAULT    = 3'd4
    } fetch_state_t;

    // Low PC bits that must be zero for an aligned instruction address
    localparam int PC_ALIGN_BITS = 2;

    // PC advance per instruction, in bytes
    function automatic int pc_step_bytes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_timeout_counter.sv
// rtl/instruction_fetch_unit_timeout_counter.sv - counts unacknowledged request cycles
module fetch_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // Count enabled cycles; clear has priority so every fetch starts from zero
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // Asserted during the TIMEOUT_CYCLES-th consecutive request cycle without ack
    assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - fetch responder: PC owner, imem req/ack, instruction latch
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  instruction_fetch,
    input  logic                  write_back,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_value,
    output logic                  instruction_complete,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_ack,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic                  fetch_fault
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(pc_step_bytes(DATA_WIDTH));

    fetch_state_t state;
    logic         pc_aligned;
    logic         timeout_clear;
    logic         timeout_enable;
    logic         timeout_expired;

    assign pc_aligned     = (pc[PC_ALIGN_BITS-1:0] == '0);
    assign timeout_clear  = (state == FS_IDLE);
    assign timeout_enable = (state == FS_WAIT_ACK) && !imem_ack;

    // PC is registered, so the address is stable for the whole request
    assign imem_addr = pc;

    fetch_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (timeout_clear),
        .enable  (timeout_enable),
        .expired (timeout_expired)
    );

    // PC: redirect on write-back or out of fault, otherwise step on write-back
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC;
        end else if (pc_load && (write_back || state == FS_FAULT)) begin
            pc <= pc_load_value;
        end else if (write_back) begin
            pc <= pc + PC_STEP;
        end
    end

    // Fetch handshake FSM with registered request, completion, fault and data latch
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state                <= FS_IDLE;
            imem_req             <= 1'b0;
            instruction_complete <= 1'b0;
            fetch_fault          <= 1'b0;
            instruction          <= '0;
        end else begin
            case (state)
                FS_IDLE: begin
                    if (instruction_fetch) begin
                        if (pc_aligned) begin
                            state    <= FS_WAIT_ACK;
                            imem_req <= 1'b1;
                        end else begin
                            state       <= FS_FAULT;
                            fetch_fault <= 1'b1;
                        end
                    end
                end
                FS_WAIT_ACK: begin
                    if (imem_ack) begin
                        instruction          <= imem_rdata;
                        imem_req             <= 1'b0;
                        instruction_complete <= 1'b1;
                        state                <= FS_DONE;
                    end else if (timeout_expired) begin
                        imem_req    <= 1'b0;
                        fetch_fault <= 1'b1;
                        state       <= FS_FAULT;
                    end
                end
                FS_DONE: begin
                    instruction_complete <= 1'b0;
                    state                <= FS_RELEASE;
                end
                FS_RELEASE: begin
                    // Wait for the control FSM to leave FETCH so one request yields one fetch
                    if (!instruction_fetch) begin
                        state <= FS_IDLE;
                    end
                end
                FS_FAULT: begin
                    if (pc_load) begin
                        fetch_fault <= 1'b0;
                        state       <= FS_IDLE;
                    end
                end
                default: begin
                    imem_req             <= 1'b0;
                    instruction_complete <= 1'b0;
                    fetch_fault          <= 1'b0;
                    state                <= FS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic        instruction_fetch;
    logic        write_back;
    logic        pc_load;
    logic [31:0] pc_load_value;
    logic        instruction_complete;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        fetch_fault;

    int          vectors = 0;
    int          miscompares = 0;
    int          complete_count = 0;
    int          req_bursts = 0;
    logic        prev_req = 1'b0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_word;

    instruction_fetch_unit #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .RESET_PC       (32'h0),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .instruction_fetch    (instruction_fetch),
        .write_back           (write_back),
        .pc_load              (pc_load),
        .pc_load_value        (pc_load_value),
        .instruction_complete (instruction_complete),
        .instruction          (instruction),
        .pc                   (pc),
        .imem_req             (imem_req),
        .imem_addr            (imem_addr),
        .imem_ack             (imem_ack),
        .imem_rdata           (imem_rdata),
        .fetch_fault          (fetch_fault)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end (actual=timeout, required=finish)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: counts request bursts and pops the scoreboard on every completion pulse
    always @(negedge clock) begin
        if (!reset_n) begin
            prev_req = 1'b0;
        end else begin
            if (imem_req && !prev_req) req_bursts++;
            prev_req = imem_req;
            if (instruction_complete) begin
                complete_count++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_complete: actual=pulse required=none (instruction=0x%08h)", instruction);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("complete_data", instruction, exp_word);
                end
            end
        end
    end

    // Raise fetch, wait for the request, ack after 'waits' idle request cycles
    task automatic fetch_ok(input logic [31:0] addr, input logic [31:0] data, input int waits);
        logic seen;
        instruction_fetch = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clock);
            seen = imem_req;
        end
        check("req_seen", {31'd0, seen}, 32'd1);
        if (!seen) return;
        check("imem_addr", imem_addr, addr);
        exp_q.push_back(data);
        repeat (waits) @(negedge clock);
        imem_ack   = 1'b1;
        imem_rdata = data;
        @(negedge clock);
        check("complete_latency", {31'd0, instruction_complete}, 32'd1);
        imem_ack = 1'b0;
    endtask

    initial begin
        int b0;
        int c0;
        int hi;
        reset_n           = 1'b0;
        instruction_fetch = 1'b0;
        write_back        = 1'b0;
        pc_load           = 1'b0;
        pc_load_value     = 32'h0;
        imem_ack          = 1'b0;
        imem_rdata        = 32'h0;

        // Reset state
        #12;
        check("reset_pc", pc, 32'h0);
        check("reset_req", {31'd0, imem_req}, 32'd0);
        check("reset_fault", {31'd0, fetch_fault}, 32'd0);
        check("reset_complete", {31'd0, instruction_complete}, 32'd0);
        check("reset_instruction", instruction, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // 1/2: fetch with two wait cycles, fetch held high afterwards
        @(posedge clock); #1;
        fetch_ok(32'h0, 32'hDEADBEEF, 2);
        check("instr_deadbeef", instruction, 32'hDEADBEEF);
        repeat (5) @(posedge clock);
        #1 instruction_fetch = 1'b0;
        @(posedge clock); #1;
        check("one_complete", complete_count, 1);
        check("one_req_burst", req_bursts, 1);
        check("req_low_after", {31'd0, imem_req}, 32'd0);

        // 3: PC wrap, redirect priority, ignored pc_load
        @(posedge clock); #1;
        write_back = 1'b1; pc_load = 1'b1; pc_load_value = 32'hFFFFFFFC;
        @(posedge clock); #1;
        pc_load = 1'b0;
        check("pc_load_top", pc, 32'hFFFFFFFC);
        @(posedge clock); #1;
        write_back = 1'b0;
        check("pc_wrap", pc, 32'h0);
        pc_load = 1'b1; pc_load_value = 32'h50;
        @(posedge clock); #1;
        check("pc_load_ignored", pc, 32'h0);
        write_back = 1'b1; pc_load_value = 32'h100;
        @(posedge clock); #1;
        write_back = 1'b0; pc_load = 1'b0;
        check("pc_load_priority", pc, 32'h100);

        // Ack in the first request cycle, then a plain increment
        @(posedge clock); #1;
        fetch_ok(32'h100, 32'h00000013, 0);
        @(posedge clock); #1;
        instruction_fetch = 1'b0;
        check("instr_0x13", instruction, 32'h00000013);
        @(posedge clock); #1;
        write_back = 1'b1;
        @(posedge clock); #1;
        write_back = 1'b0;
        check("pc_increment", pc, 32'h104);

        // 4: misaligned PC faults without a request
        write_back = 1'b1; pc_load = 1'b1; pc_load_value = 32'h102;
        @(posedge clock); #1;
        write_back = 1'b0; pc_load = 1'b0;
        check("pc_misaligned", pc, 32'h102);
        b0 = req_bursts;
        c0 = complete_count;
        instruction_fetch = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("misalign_fault", {31'd0, fetch_fault}, 32'd1);
        check("misalign_no_req", {31'd0, imem_req}, 32'd0);
        check("misalign_no_burst", req_bursts, b0);
        instruction_fetch = 1'b0;
        pc_load = 1'b1; pc_load_value = 32'h200;
        @(posedge clock); #1;
        pc_load = 1'b0;
        check("fault_cleared", {31'd0, fetch_fault}, 32'd0);
        check("fault_redirect_pc", pc, 32'h200);

        // 5: ack never arrives
        @(posedge clock); #1;
        instruction_fetch = 1'b1;
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (imem_req) hi++;
            else if (hi > 0) break;
        end
        check("timeout_req_cycles", hi, 16);
        check("timeout_fault", {31'd0, fetch_fault}, 32'd1);
        instruction_fetch = 1'b0;
        @(posedge clock); #1;
        check("timeout_no_complete", complete_count, c0);
        pc_load = 1'b1; pc_load_value = 32'h300;
        @(posedge clock); #1;
        pc_load = 1'b0;
        check("timeout_recover_pc", pc, 32'h300);

        // 6: async reset mid-request, later ack ignored
        @(posedge clock); #1;
        instruction_fetch = 1'b1;
        repeat (3) @(negedge clock);
        check("req_before_reset", {31'd0, imem_req}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("reset_drops_req", {31'd0, imem_req}, 32'd0);
        check("reset_pc_midfetch", pc, 32'h0);
        instruction_fetch = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        c0 = complete_count;
        imem_ack = 1'b1; imem_rdata = 32'h00000BAD;
        repeat (3) @(posedge clock);
        #1;
        imem_ack = 1'b0;
        check("late_ack_instr", instruction, 32'h0);
        check("late_ack_no_complete", complete_count, c0);
        check("late_ack_no_req", {31'd0, imem_req}, 32'd0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
